// File: rtl/mul_share_arbiter_if.sv
// Bundle of request, response and multiplier-side signals for mul_share_arbiter.
// The slave modport is the arbiter; the master modport is the client/multiplier environment.
interface mul_share_arbiter_if #(
  parameter int MAG_W = 2
);
  logic               req0_valid;
  logic               req0_ready;
  logic [MAG_W:0]     req0_a;
  logic [MAG_W:0]     req0_b;
  logic               req1_valid;
  logic               req1_ready;
  logic [MAG_W:0]     req1_a;
  logic [MAG_W:0]     req1_b;
  logic               resp0_valid;
  logic               resp0_ready;
  logic [2*MAG_W:0]   resp0_product;
  logic               resp0_zero;
  logic               resp1_valid;
  logic               resp1_ready;
  logic [2*MAG_W:0]   resp1_product;
  logic               resp1_zero;
  logic [MAG_W:0]     mul_a;
  logic [MAG_W:0]     mul_b;
  logic [2*MAG_W:0]   mul_product;
  logic               mul_zero;
  logic               busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  resp0_ready, resp1_ready, mul_product, mul_zero,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_product, resp0_zero,
    output resp1_valid, resp1_product, resp1_zero,
    output mul_a, mul_b, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output resp0_ready, resp1_ready, mul_product, mul_zero,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_product, resp0_zero,
    input  resp1_valid, resp1_product, resp1_zero,
    input  mul_a, mul_b, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one combinational sign-magnitude multiplier between two
// requesters; one transaction in flight, IDLE -> EXEC -> RESP.
module mul_share_arbiter #(
  parameter int MAG_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  mul_share_arbiter_if.slave  bus
);
  localparam int OP_W = MAG_W + 1;
  localparam int PR_W = 2 * MAG_W + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state;
  logic              r_prio1;   // 1: requester 1 wins a tie
  logic              r_owner;
  logic              r_busy;
  logic [OP_W-1:0]   r_mul_a;
  logic [OP_W-1:0]   r_mul_b;
  logic              r_resp0_valid;
  logic              r_resp1_valid;
  logic [PR_W-1:0]   r_resp0_product;
  logic [PR_W-1:0]   r_resp1_product;
  logic              r_resp0_zero;
  logic              r_resp1_zero;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_resp_take;

  always_comb begin
    w_grant1    = bus.req1_valid & (~bus.req0_valid | r_prio1);
    w_grant0    = bus.req0_valid & ~w_grant1;
    w_resp_take = r_owner ? bus.resp1_ready : bus.resp0_ready;
  end

  assign bus.req0_ready    = (r_state == IDLE) & w_grant0;
  assign bus.req1_ready    = (r_state == IDLE) & w_grant1;
  assign bus.resp0_valid   = r_resp0_valid;
  assign bus.resp1_valid   = r_resp1_valid;
  assign bus.resp0_product = r_resp0_product;
  assign bus.resp1_product = r_resp1_product;
  assign bus.resp0_zero    = r_resp0_zero;
  assign bus.resp1_zero    = r_resp1_zero;
  assign bus.mul_a         = r_mul_a;
  assign bus.mul_b         = r_mul_b;
  assign bus.busy          = r_busy;

  // The multiplier operand registers double as the latched request operands:
  // they are non-zero only while in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_prio1         <= 1'b0;
      r_owner         <= 1'b0;
      r_busy          <= 1'b0;
      r_mul_a         <= '0;
      r_mul_b         <= '0;
      r_resp0_valid   <= 1'b0;
      r_resp1_valid   <= 1'b0;
      r_resp0_product <= '0;
      r_resp1_product <= '0;
      r_resp0_zero    <= 1'b0;
      r_resp1_zero    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant0 | w_grant1) begin
            r_mul_a <= w_grant1 ? bus.req1_a : bus.req0_a;
            r_mul_b <= w_grant1 ? bus.req1_b : bus.req0_b;
            r_owner <= w_grant1;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (r_owner) begin
            r_resp1_product <= bus.mul_product;
            r_resp1_zero    <= bus.mul_zero;
            r_resp1_valid   <= 1'b1;
          end else begin
            r_resp0_product <= bus.mul_product;
            r_resp0_zero    <= bus.mul_zero;
            r_resp0_valid   <= 1'b1;
          end
          r_mul_a <= '0;
          r_mul_b <= '0;
          r_state <= RESP;
        end
        RESP: begin
          if (w_resp_take) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_prio1       <= ~r_owner;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
